// File: rtl/register_file_mp.sv
// Multi-port register file with a per-register busy scoreboard.
// It supports optional same-cycle write forwarding and optional registered read data.
module register_file_mp #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int RD_PORTS = 2,
  parameter int BYPASS   = 1,
  parameter int REG_READ = 0,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       RegWriteControl,
  input  logic [AW-1:0]              RegWriteAddr,
  input  logic [DATA_W-1:0]          RegDataIn,
  input  logic [RD_PORTS*AW-1:0]     RegReadAddr,
  output logic [RD_PORTS*DATA_W-1:0] RegDataOut,
  input  logic                       ScbSet,
  input  logic [AW-1:0]              ScbSetAddr,
  output logic [RD_PORTS-1:0]        RegBusy
);

  // Storage covers the whole address space, so an index is never out of bounds.
  // Entries at DEPTH and above are never written and therefore stay 0.
  localparam int          NREG    = 1 << AW;
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [DATA_W-1:0]          regs [NREG];
  logic [NREG-1:0]            busy;
  logic [RD_PORTS*DATA_W-1:0] rd_data;
  logic [RD_PORTS-1:0]        rd_busy;
  logic [AW-1:0]              rd_addr;
  logic                       write_ok;
  logic                       set_ok;

  assign write_ok = RegWriteControl && (RegWriteAddr != '0) && ({1'b0, RegWriteAddr} < DEPTH_L);
  assign set_ok   = ScbSet && (ScbSetAddr != '0) && ({1'b0, ScbSetAddr} < DEPTH_L);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (write_ok) begin
      regs[RegWriteAddr] <= RegDataIn;
    end
  end

  // The set is applied after the clear, so a new producer wins over a retiring write.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy <= '0;
    end else begin
      if (write_ok) busy[RegWriteAddr] <= 1'b0;
      if (set_ok)   busy[ScbSetAddr]   <= 1'b1;
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    rd_addr = '0;
    for (int p = 0; p < RD_PORTS; p++) begin
      rd_addr = RegReadAddr[p*AW +: AW];
      if ((rd_addr != '0) && ({1'b0, rd_addr} < DEPTH_L)) begin
        rd_data[p*DATA_W +: DATA_W] = regs[rd_addr];
        rd_busy[p]                  = busy[rd_addr];
        if ((BYPASS != 0) && write_ok && (RegWriteAddr == rd_addr)) begin
          rd_data[p*DATA_W +: DATA_W] = RegDataIn;
          if (!(set_ok && (ScbSetAddr == rd_addr))) rd_busy[p] = 1'b0;
        end
      end
    end
  end

  generate
    if (REG_READ != 0) begin : g_reg_read
      always_ff @(posedge clock or posedge reset) begin
        if (reset) RegDataOut <= '0;
        else       RegDataOut <= rd_data;
      end
    end else begin : g_comb_read
      assign RegDataOut = rd_data;
    end
  endgenerate

  assign RegBusy = rd_busy;

endmodule

// File: doc/register_file_mp.md
REGISTER_FILE_MP -- requirements
Module: register_file_mp

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, data word width in bits.
REQ-002 SHALL provide parameter DEPTH, default 32, number of architectural registers (2..64).
REQ-003 SHALL provide parameter RD_PORTS, default 2, number of independent read ports (1..4).
REQ-004 SHALL provide parameter BYPASS, default 1, 1 = same-cycle write data forwarded to matching reads.
REQ-005 SHALL provide parameter REG_READ, default 0, 0 = combinational reads, 1 = registered reads (one-cycle latency).
REQ-006 SHALL derive AW = $clog2(DEPTH) for all address fields.
REQ-007 SHALL have port clock  input  1  single rising-edge clock.
REQ-008 SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-009 SHALL have port RegWriteControl  input  1  write enable.
REQ-010 SHALL have port RegWriteAddr  input  AW  write address.
REQ-011 SHALL have port RegDataIn  input  DATA_W  write data.
REQ-012 SHALL have port RegReadAddr  input  RD_PORTS*AW  packed read addresses, port p at bits [p*AW +: AW].
REQ-013 SHALL have port RegDataOut  output  RD_PORTS*DATA_W  packed read data, port p at bits [p*DATA_W +: DATA_W].
REQ-014 SHALL have port ScbSet  input  1  mark register ScbSetAddr busy (result pending).
REQ-015 SHALL have port ScbSetAddr  input  AW  register to mark busy.
REQ-016 SHALL have port RegBusy  output  RD_PORTS  busy flag per read port for its addressed register.

Function
REQ-017 SHALL write RegDataIn into register RegWriteAddr on rising clock when RegWriteControl=1.
REQ-018 SHALL ignore writes to address 0; register 0 SHALL always read 0.
REQ-019 SHALL ignore writes and ScbSet to addresses >= DEPTH; reads of addresses >= DEPTH SHALL return 0, busy 0.
REQ-020 SHALL, with REG_READ=0, drive each RegDataOut port combinationally from the stored value of its address.
REQ-021 SHALL, with REG_READ=1, capture read data on rising clock so RegDataOut reflects the address presented one cycle earlier.
REQ-022 SHALL, with BYPASS=1, return RegDataIn on any read port whose address equals RegWriteAddr while RegWriteControl=1 and address != 0 (before the register update, for REG_READ=0; into the output register, for REG_READ=1).
REQ-023 SHALL, with BYPASS=0, return the pre-write stored value on a same-cycle read of the written address.
REQ-024 SHALL maintain one busy bit per register; ScbSet=1 sets bit ScbSetAddr on rising clock.
REQ-025 SHALL clear busy bit RegWriteAddr on rising clock when RegWriteControl=1.
REQ-026 SHALL, on simultaneous ScbSet and write to the same address, leave the bit set (new producer wins).
REQ-027 SHALL never set busy bit 0.
REQ-028 SHALL drive RegBusy[p] combinationally from the busy bit of port p's address; with BYPASS=1 a same-cycle clearing write to that address SHALL drive RegBusy[p]=0.
REQ-029 SHALL allow multiple read ports to address the same register with identical results.

Reset
REQ-030 SHALL, while reset=1, asynchronously clear all registers, all busy bits, and (REG_READ=1) all RegDataOut output registers to 0.
REQ-031 SHALL ignore writes and ScbSet while reset=1; operation SHALL resume on the first rising clock after reset deasserts.
REQ-032 SHALL, on reset asserted mid-operation, discard pending busy state so RegBusy reads 0 afterwards.

Verification
REQ-033 Write 897 to r1, next cycle read port0=r1, port1=r2 -> RegDataOut port0=897, port1=0.
REQ-034 BYPASS=1, REG_READ=0: write 666 to r2 while port1 reads r2 -> port1=666 same cycle; BYPASS=0 -> port1 shows old value, 666 next cycle.
REQ-035 Write 0xDEADBEEF to r0, read r0 on all ports -> 0; ScbSet on r0 -> RegBusy 0.
REQ-036 ScbSet r5, read r5 -> RegBusy=1 next cycle; write 42 to r5 -> RegBusy=0, data 42; simultaneous ScbSet+write r5 -> RegBusy stays 1, data updated.
REQ-037 REG_READ=1: present address r1 (holding 897) -> RegDataOut=897 exactly one cycle later, not earlier.
REQ-038 Load r3=65 and ScbSet r4, pulse reset asynchronously mid-cycle -> r3 reads 0, RegBusy for r4 = 0 immediately.
